// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the multi-port register file and its scoreboard:
//   - default geometry (XLEN, NREG, NR, NW)
//   - the index of the hardwired-zero register x0
//   - highest_write_port(): picks the winning write port among several that
//     target the same register (highest port index wins)
// ---------------------------------------------------------------------------
package regfile_pkg;

    localparam int DEF_XLEN = 32;
    localparam int DEF_NREG = 32;
    localparam int DEF_NR   = 2;
    localparam int DEF_NW   = 1;

    // x0 always reads zero, is never busy and is never reservable.
    localparam int X0 = 0;

    // Upper bound on the number of write ports the priority helper handles.
    // Instances with NW above this value are not supported.
    localparam int MAX_WPORTS = 8;

    typedef logic [MAX_WPORTS-1:0] wport_vec_t;

    // Given a vector of write ports that hit some address, return a one-hot
    // vector marking the highest-index hitting port (all zero if none hit).
    function automatic wport_vec_t highest_write_port(input wport_vec_t hits);
        wport_vec_t sel;
        sel = '0;
        for (int j = 0; j < MAX_WPORTS; j++) begin
            if (hits[j]) begin
                sel    = '0;
                sel[j] = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage : regfile_pkg

// File: rtl/register_file_mp_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_scoreboard
// Per-register busy scoreboard with a reserve/ready handshake.
//   clk          in   clock
//   reset        in   asynchronous active-high reset, clears all busy bits
//   i_rsv_adr    in   register to reserve
//   i_rsv_valid  in   reservation request
//   i_flush      in   clear every busy bit at the next edge (beats sets)
//   i_wadr       in   NW packed write addresses
//   i_wen        in   NW write enables; each enabled port releases its address
//   o_rsv_ready  out  reservation can be accepted this cycle
//   o_busy_vec   out  busy bit per register
// ---------------------------------------------------------------------------
module reg_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREG = DEF_NREG,
    parameter int NW   = DEF_NW,
    parameter int AW   = $clog2(NREG)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [AW-1:0]      i_rsv_adr,
    input  logic               i_rsv_valid,
    input  logic               i_flush,
    input  logic [NW*AW-1:0]   i_wadr,
    input  logic [NW-1:0]      i_wen,
    output logic               o_rsv_ready,
    output logic [NREG-1:0]    o_busy_vec
);

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_set;
    logic [NREG-1:0] w_clr;
    logic [NREG-1:0] w_next;
    logic            w_accept;

    // A register that is still waiting for its writeback cannot be reserved
    // again (write-after-write stall). Flush and reset also block new
    // reservations. x0 is never busy, so reserving it is accepted as a no-op.
    assign o_rsv_ready = ~reset & ~i_flush & ~r_busy[i_rsv_adr];
    assign w_accept    = i_rsv_valid & o_rsv_ready;

    // Next busy vector: writebacks release, an accepted reservation sets and
    // wins over a same-cycle release, flush clears everything.
    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (w_accept && (i_rsv_adr != AW'(X0))) begin
            w_set[i_rsv_adr] = 1'b1;
        end
        for (int j = 0; j < NW; j++) begin
            if (i_wen[j]) begin
                w_clr[i_wadr[j*AW +: AW]] = 1'b1;
            end
        end
        if (i_flush) begin
            w_next = '0;
        end else begin
            w_next = (r_busy & ~w_clr) | w_set;
        end
        w_next[X0] = 1'b0;
    end

    // Busy state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_next;
        end
    end

    assign o_busy_vec = r_busy;

endmodule : reg_scoreboard

// File: rtl/register_file_mp.sv
// ---------------------------------------------------------------------------
// register_file_mp
// Multi-port register file: NREG GPRs (x0 hardwired to zero), a PC register,
// NR combinational read ports, NW prioritised write ports, optional
// write-to-read bypass and a busy scoreboard with reserve/ready handshake.
//   clk, reset               clock / asynchronous active-high reset
//   PC_INIT                  PC value loaded while reset is high
//   RADR_SD / RDATA_SR       packed read addresses / read data
//   RBUSY_SR                 busy flag of each read address
//   WADR_SW/WDATA_SW/        packed write addresses, data and enables
//   WENABLE_SW                 (highest port index wins on collisions)
//   RSV_ADR_SD/RSV_VALID_SD  reservation request
//   RSV_READY_SR             reservation can be accepted
//   FLUSH_SD                 clear all busy bits
//   WRITE_PC_SD/_ENABLE_SD   PC update
//   READ_PC_SR               current PC
//   BUSY_VEC_SR              full scoreboard
// ---------------------------------------------------------------------------
module register_file_mp
    import regfile_pkg::*;
#(
    parameter int XLEN   = DEF_XLEN,
    parameter int NREG   = DEF_NREG,
    parameter int NR     = DEF_NR,
    parameter int NW     = DEF_NW,
    parameter int BYPASS = 1,
    parameter int AW     = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [XLEN-1:0]     PC_INIT,
    input  logic [NR*AW-1:0]    RADR_SD,
    output logic [NR*XLEN-1:0]  RDATA_SR,
    output logic [NR-1:0]       RBUSY_SR,
    input  logic [NW*AW-1:0]    WADR_SW,
    input  logic [NW*XLEN-1:0]  WDATA_SW,
    input  logic [NW-1:0]       WENABLE_SW,
    input  logic [AW-1:0]       RSV_ADR_SD,
    input  logic                RSV_VALID_SD,
    output logic                RSV_READY_SR,
    input  logic                FLUSH_SD,
    input  logic [XLEN-1:0]     WRITE_PC_SD,
    input  logic                WRITE_PC_ENABLE_SD,
    output logic [XLEN-1:0]     READ_PC_SR,
    output logic [NREG-1:0]     BUSY_VEC_SR
);

    logic [XLEN-1:0] r_regs [NREG];
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_next [NREG];
    logic [AW-1:0]   w_wadr [NW];
    logic [XLEN-1:0] w_wdata [NW];
    logic [NREG-1:0] w_busy;

    // Unpack the write ports once so the logic below can index them.
    for (genvar j = 0; j < NW; j++) begin : g_wport
        assign w_wadr[j]  = WADR_SW[j*AW +: AW];
        assign w_wdata[j] = WDATA_SW[j*XLEN +: XLEN];
    end

    // Next value of every register: the highest enabled port addressing it
    // supplies the data. x0 is excluded from the match, so it stays zero.
    always_comb begin : p_write_sel
        wport_vec_t v_hits;
        wport_vec_t v_sel;
        for (int g = 0; g < NREG; g++) begin
            w_next[g] = r_regs[g];
            v_hits    = '0;
            for (int j = 0; j < NW; j++) begin
                v_hits[j] = WENABLE_SW[j] && (w_wadr[j] == AW'(g)) && (g != X0);
            end
            v_sel = highest_write_port(v_hits);
            for (int j = 0; j < NW; j++) begin
                if (v_sel[j]) begin
                    w_next[g] = w_wdata[j];
                end
            end
        end
    end

    // GPR storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int g = 0; g < NREG; g++) begin
                r_regs[g] <= '0;
            end
        end else begin
            for (int g = 0; g < NREG; g++) begin
                r_regs[g] <= w_next[g];
            end
        end
    end

    // Read ports. With bypass enabled, a same-cycle write to the read address
    // forwards its data and masks the busy flag, since that write is the
    // result the reader would otherwise be waiting for.
    always_comb begin : p_read
        logic [AW-1:0]   v_adr;
        logic [XLEN-1:0] v_data;
        wport_vec_t      v_hits;
        wport_vec_t      v_sel;
        RDATA_SR = '0;
        RBUSY_SR = '0;
        for (int i = 0; i < NR; i++) begin
            v_adr  = RADR_SD[i*AW +: AW];
            v_hits = '0;
            if (BYPASS != 0) begin
                for (int j = 0; j < NW; j++) begin
                    v_hits[j] = WENABLE_SW[j] && (w_wadr[j] == v_adr) && (v_adr != AW'(X0));
                end
            end
            v_sel  = highest_write_port(v_hits);
            v_data = r_regs[v_adr];
            for (int j = 0; j < NW; j++) begin
                if (v_sel[j]) begin
                    v_data = w_wdata[j];
                end
            end
            RDATA_SR[i*XLEN +: XLEN] = reset ? '0 : v_data;
            RBUSY_SR[i]              = ~reset & w_busy[v_adr] & ~(|v_sel);
        end
    end

    // PC register, independent of the GPR ports.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc <= PC_INIT;
        end else if (WRITE_PC_ENABLE_SD) begin
            r_pc <= WRITE_PC_SD;
        end
    end

    // While reset is held the PC output follows PC_INIT directly, so a change
    // of PC_INIT during reset is visible without waiting for another edge.
    assign READ_PC_SR = reset ? PC_INIT : r_pc;

    reg_scoreboard #(
        .NREG (NREG),
        .NW   (NW),
        .AW   (AW)
    ) u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .i_rsv_adr   (RSV_ADR_SD),
        .i_rsv_valid (RSV_VALID_SD),
        .i_flush     (FLUSH_SD),
        .i_wadr      (WADR_SW),
        .i_wen       (WENABLE_SW),
        .o_rsv_ready (RSV_READY_SR),
        .o_busy_vec  (w_busy)
    );

    assign BUSY_VEC_SR = w_busy;

endmodule : register_file_mp

// File: tb/tb_register_file_mp.sv
// ---------------------------------------------------------------------------
// tb_register_file_mp
// Two instances (BYPASS=1 and BYPASS=0, NW=2, NR=2) share one stimulus
// stream; a behavioural model of the register file predicts every output.
// ---------------------------------------------------------------------------
module tb_register_file_mp;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NR   = 2;
    localparam int NW   = 2;
    localparam int AW   = 5;

    logic                clk = 1'b0;
    logic                reset;
    logic [XLEN-1:0]     pcInit;
    logic [NR*AW-1:0]    radr;
    logic [NW*AW-1:0]    wadr;
    logic [NW*XLEN-1:0]  wdata;
    logic [NW-1:0]       wen;
    logic [AW-1:0]       rsvAdr;
    logic                rsvValid;
    logic                flush;
    logic [XLEN-1:0]     pcData;
    logic                pcEn;

    logic [NR*XLEN-1:0]  rdataB, rdataN;
    logic [NR-1:0]       rbusyB, rbusyN;
    logic                readyB, readyN;
    logic [XLEN-1:0]     pcB, pcN;
    logic [NREG-1:0]     busyVecB, busyVecN;

    logic [XLEN-1:0]     modelRegs [NREG];
    logic [NREG-1:0]     modelBusy;
    logic [XLEN-1:0]     modelPc;

    int checkCount = 0;
    int passCount  = 0;

    always #5 clk = ~clk;

    register_file_mp #(.XLEN(XLEN), .NREG(NREG), .NR(NR), .NW(NW), .BYPASS(1)) dutByp (
        .clk(clk), .reset(reset), .PC_INIT(pcInit),
        .RADR_SD(radr), .RDATA_SR(rdataB), .RBUSY_SR(rbusyB),
        .WADR_SW(wadr), .WDATA_SW(wdata), .WENABLE_SW(wen),
        .RSV_ADR_SD(rsvAdr), .RSV_VALID_SD(rsvValid), .RSV_READY_SR(readyB),
        .FLUSH_SD(flush), .WRITE_PC_SD(pcData), .WRITE_PC_ENABLE_SD(pcEn),
        .READ_PC_SR(pcB), .BUSY_VEC_SR(busyVecB)
    );

    register_file_mp #(.XLEN(XLEN), .NREG(NREG), .NR(NR), .NW(NW), .BYPASS(0)) dutNoByp (
        .clk(clk), .reset(reset), .PC_INIT(pcInit),
        .RADR_SD(radr), .RDATA_SR(rdataN), .RBUSY_SR(rbusyN),
        .WADR_SW(wadr), .WDATA_SW(wdata), .WENABLE_SW(wen),
        .RSV_ADR_SD(rsvAdr), .RSV_VALID_SD(rsvValid), .RSV_READY_SR(readyN),
        .FLUSH_SD(flush), .WRITE_PC_SD(pcData), .WRITE_PC_ENABLE_SD(pcEn),
        .READ_PC_SR(pcN), .BUSY_VEC_SR(busyVecN)
    );

    // One comparison: count it, and report tag/observed/expected on failure.
    task automatic checkVal(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    endtask

    // Reset puts the model into its power-on state immediately.
    task automatic modelReset();
        for (int r = 0; r < NREG; r++) modelRegs[r] = '0;
        modelBusy = '0;
        modelPc   = pcInit;
    endtask

    // Architectural effect of one rising edge: writes applied in port order
    // (so a later port overwrites an earlier one), releases before the
    // reservation, flush clears the scoreboard outright.
    task automatic modelClockEdge();
        logic [AW-1:0] a;
        logic          accept;
        accept = rsvValid && !flush && !modelBusy[rsvAdr];
        for (int j = 0; j < NW; j++) begin
            a = wadr[j*AW +: AW];
            if (wen[j] && a != 0) modelRegs[a] = wdata[j*XLEN +: XLEN];
        end
        if (flush) begin
            modelBusy = '0;
        end else begin
            for (int j = 0; j < NW; j++) begin
                if (wen[j]) modelBusy[wadr[j*AW +: AW]] = 1'b0;
            end
            if (accept && rsvAdr != 0) modelBusy[rsvAdr] = 1'b1;
        end
        modelBusy[0] = 1'b0;
        if (pcEn) modelPc = pcData;
    endtask

    // Compare every output of both instances with the model's prediction.
    task automatic checkOutput();
        logic [AW-1:0]   a;
        logic [XLEN-1:0] expData;
        logic            expBusy;
        logic            forwarded;
        logic [XLEN-1:0] obsData;
        logic            obsBusy;
        string           pfx;
        for (int b = 0; b < 2; b++) begin
            pfx = (b == 0) ? "byp" : "nobyp";
            for (int i = 0; i < NR; i++) begin
                a         = radr[i*AW +: AW];
                expData   = (a == 0) ? '0 : modelRegs[a];
                forwarded = 1'b0;
                if (b == 0 && a != 0) begin
                    for (int j = 0; j < NW; j++) begin
                        if (wen[j] && wadr[j*AW +: AW] == a) begin
                            expData   = wdata[j*XLEN +: XLEN];
                            forwarded = 1'b1;
                        end
                    end
                end
                expBusy = modelBusy[a] && !forwarded;
                if (reset) begin
                    expData = '0;
                    expBusy = 1'b0;
                end
                obsData = (b == 0) ? rdataB[i*XLEN +: XLEN] : rdataN[i*XLEN +: XLEN];
                obsBusy = (b == 0) ? rbusyB[i] : rbusyN[i];
                checkVal($sformatf("%s.rdata%0d(x%0d)", pfx, i, a), 64'(obsData), 64'(expData));
                checkVal($sformatf("%s.rbusy%0d(x%0d)", pfx, i, a), 64'(obsBusy), 64'(expBusy));
            end
            checkVal({pfx, ".busyVec"}, 64'((b == 0) ? busyVecB : busyVecN), 64'(reset ? '0 : modelBusy));
            checkVal({pfx, ".rsvReady"}, 64'((b == 0) ? readyB : readyN),
                     64'(!reset && !flush && !modelBusy[rsvAdr]));
            checkVal({pfx, ".pc"}, 64'((b == 0) ? pcB : pcN), 64'(reset ? pcInit : modelPc));
        end
    endtask

    // Drive one cycle's worth of inputs.
    task automatic applyStimulus(
        input logic [AW-1:0] r0, input logic [AW-1:0] r1,
        input logic we0, input logic [AW-1:0] wa0, input logic [XLEN-1:0] wd0,
        input logic we1, input logic [AW-1:0] wa1, input logic [XLEN-1:0] wd1,
        input logic rv, input logic [AW-1:0] ra, input logic fl,
        input logic pe, input logic [XLEN-1:0] pd);
        radr     = {r1, r0};
        wen      = {we1, we0};
        wadr     = {wa1, wa0};
        wdata    = {wd1, wd0};
        rsvValid = rv;
        rsvAdr   = ra;
        flush    = fl;
        pcEn     = pe;
        pcData   = pd;
    endtask

    // Check mid-cycle, then advance the model across the rising edge.
    task automatic runCycle();
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        if (!reset) modelClockEdge();
        #1;
    endtask

    initial begin
        // Reset state, including a write attempt that must stay invisible.
        pcInit = 32'h8000_0000;
        reset  = 1'b1;
        applyStimulus(5, 0, 1, 5, 32'hFFFF_FFFF, 0, 0, 0, 1, 6, 0, 0, 0);
        modelReset();
        runCycle();
        reset = 1'b0;
        applyStimulus(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        runCycle();

        // Both ports write x3: port 1 wins. Then a write to x0 is ignored.
        applyStimulus(3, 0, 1, 3, 32'hAAAA, 1, 3, 32'h5555, 0, 0, 0, 0, 0);
        runCycle();
        applyStimulus(3, 0, 1, 0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0, 0);
        runCycle();
        applyStimulus(0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        runCycle();

        // Write x7 while reading it: forwarded only on the bypass instance.
        applyStimulus(7, 7, 1, 7, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 0);
        runCycle();
        applyStimulus(7, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        runCycle();

        // Reserve x4, then observe the write-after-write stall.
        applyStimulus(4, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0);
        runCycle();
        applyStimulus(4, 0, 0, 0, 0, 0, 0, 0, 0, 4, 0, 0, 0);
        runCycle();
        // Writeback x4 while it is still busy: the new reserve is refused.
        applyStimulus(4, 0, 1, 4, 32'h4444, 0, 0, 0, 1, 4, 0, 0, 0);
        runCycle();
        // Writeback x4 plus an accepted reserve of x4: set wins.
        applyStimulus(4, 0, 0, 0, 0, 1, 4, 32'h4545, 1, 4, 0, 0, 0);
        runCycle();
        applyStimulus(4, 0, 0, 0, 0, 0, 0, 0, 0, 4, 0, 0, 0);
        runCycle();
        // Reserving x0 is a no-op.
        applyStimulus(0, 4, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        runCycle();

        // Reserve x9 and x10, then flush with a reservation of x11 pending.
        applyStimulus(9, 10, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0);
        runCycle();
        applyStimulus(9, 10, 0, 0, 0, 0, 0, 0, 1, 10, 0, 0, 0);
        runCycle();
        applyStimulus(3, 7, 0, 0, 0, 0, 0, 0, 1, 11, 1, 0, 0);
        runCycle();
        applyStimulus(3, 7, 0, 0, 0, 0, 0, 0, 0, 11, 0, 0, 0);
        runCycle();

        // PC update and fresh reservations, then a mid-cycle reset.
        applyStimulus(3, 4, 0, 0, 0, 0, 0, 0, 1, 12, 0, 1, 32'h100);
        runCycle();
        applyStimulus(3, 12, 0, 0, 0, 0, 0, 0, 1, 13, 0, 0, 0);
        runCycle();
        applyStimulus(3, 13, 0, 0, 0, 0, 0, 0, 0, 13, 0, 0, 0);
        reset = 1'b1;
        modelReset();
        runCycle();
        reset = 1'b0;
        applyStimulus(3, 4, 1, 8, 32'h8888, 0, 0, 0, 1, 8, 0, 0, 0);
        runCycle();

        // Randomised traffic on a narrow address range to force collisions.
        for (int n = 0; n < 400; n++) begin
            applyStimulus(
                AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom,
                1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom,
                1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
                ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 7) == 0), $urandom);
            if ($urandom_range(0, 49) == 0) begin
                reset = 1'b1;
                modelReset();
            end else begin
                reset = 1'b0;
            end
            runCycle();
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule : tb_register_file_mp
